// File: rtl/gps_ca_code_gen.sv
// -----------------------------------------------------------------------------
// gps_ca_code_gen
//   GPS L1 C/A Gold-code generator. G1 (x^3+x^10) and G2
//   (x^2+x^3+x^6+x^8+x^9+x^10) run 1023 chips per 1 ms epoch. The chip output
//   is G1[10] xor the two G2 phase-select taps belonging to the active PRN.
//   Advances on the single-cycle chip_en strobe from the chip prescaler.
//
// Optional feature: define CA_CODE_SLEW_EN to add the slew_req/slew_dir
//   ports for one-chip code-phase corrections (retard = hold one chip_en,
//   advance = double step on one chip_en).
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   chip_en    in   one-cycle chip strobe
//   prn_valid  in   PRN load request
//   prn        in   requested PRN (1..32)
//   prn_ready  out  1 except while rst is asserted
//   prn_err    out  1-cycle pulse after a request with prn==0 or prn>32
//   stop       in   return to IDLE (wins over a simultaneous request)
//   running    out  1 while in RUN
//   ca_chip    out  current chip (0 in IDLE)
//   chip_idx   out  index of the current chip, 0..1022
//   epoch      out  1-cycle pulse the cycle after the 1022->0 wrap
//   bit_edge   out  coincides with every MS_PER_BIT-th epoch
//   slew_req   in   (CA_CODE_SLEW_EN) arm one correction
//   slew_dir   in   (CA_CODE_SLEW_EN) 0 = retard, 1 = advance
// -----------------------------------------------------------------------------
module gps_ca_code_gen #(
  parameter int PRN_W      = 6,
  parameter int MS_PER_BIT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_en,
  input  logic             prn_valid,
  input  logic [PRN_W-1:0] prn,
  output logic             prn_ready,
  output logic             prn_err,
  input  logic             stop,
  output logic             running,
  output logic             ca_chip,
  output logic [9:0]       chip_idx,
  output logic             epoch,
  output logic             bit_edge
`ifdef CA_CODE_SLEW_EN
  ,
  input  logic             slew_req,
  input  logic             slew_dir
`endif
);

  localparam int MS_W = (MS_PER_BIT > 1) ? $clog2(MS_PER_BIT) : 1;
  localparam logic [9:0] LAST_IDX = 10'd1022;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [10:1]     g1_reg, g1_next;
  logic [10:1]     g2_reg, g2_next;
  logic [9:0]      idx_reg, idx_next;
  logic [MS_W-1:0] ms_reg, ms_next;
  logic [7:0]      taps_reg, taps_next;        // {tap_a, tap_b}, stage numbers 1..10
  logic [7:0]      pend_taps_reg, pend_taps_next;
  logic            pend_valid_reg, pend_valid_next;
  logic            epoch_reg, epoch_next;
  logic            bit_edge_reg, bit_edge_next;
  logic            prn_err_reg, prn_err_next;

`ifdef CA_CODE_SLEW_EN
  logic            slew_armed_reg, slew_armed_next;
  logic            slew_adv_reg, slew_adv_next;
`endif

  logic            prn_ok;
  logic            req_ok;
  logic [4:0]      prn_sel;
  logic [7:0]      req_taps;
  logic [1:0]      steps;       // register shifts applied on this chip_en
  logic            wrap;
  logic [10:1]     tap_hit_a, tap_hit_b;

  // G2 phase-select tap pairs, indexed by PRN-1 (PRN32 falls to default).
  function automatic logic [7:0] g2_taps(input logic [4:0] sel);
    logic [7:0] t;
    case (sel)
      5'd0:    t = {4'd2, 4'd6};
      5'd1:    t = {4'd3, 4'd7};
      5'd2:    t = {4'd4, 4'd8};
      5'd3:    t = {4'd5, 4'd9};
      5'd4:    t = {4'd1, 4'd9};
      5'd5:    t = {4'd2, 4'd10};
      5'd6:    t = {4'd1, 4'd8};
      5'd7:    t = {4'd2, 4'd9};
      5'd8:    t = {4'd3, 4'd10};
      5'd9:    t = {4'd2, 4'd3};
      5'd10:   t = {4'd3, 4'd4};
      5'd11:   t = {4'd5, 4'd6};
      5'd12:   t = {4'd6, 4'd7};
      5'd13:   t = {4'd7, 4'd8};
      5'd14:   t = {4'd8, 4'd9};
      5'd15:   t = {4'd9, 4'd10};
      5'd16:   t = {4'd1, 4'd4};
      5'd17:   t = {4'd2, 4'd5};
      5'd18:   t = {4'd3, 4'd6};
      5'd19:   t = {4'd4, 4'd7};
      5'd20:   t = {4'd5, 4'd8};
      5'd21:   t = {4'd6, 4'd9};
      5'd22:   t = {4'd1, 4'd3};
      5'd23:   t = {4'd4, 4'd6};
      5'd24:   t = {4'd5, 4'd7};
      5'd25:   t = {4'd6, 4'd8};
      5'd26:   t = {4'd7, 4'd9};
      5'd27:   t = {4'd8, 4'd10};
      5'd28:   t = {4'd1, 4'd6};
      5'd29:   t = {4'd2, 4'd7};
      5'd30:   t = {4'd3, 4'd8};
      default: t = {4'd4, 4'd9};
    endcase
    return t;
  endfunction

  // Stage 1 receives the feedback; stage 10 is the output stage.
  function automatic logic [10:1] g1_step(input logic [10:1] r);
    return {r[9:1], r[3] ^ r[10]};
  endfunction

  function automatic logic [10:1] g2_step(input logic [10:1] r);
    return {r[9:1], r[2] ^ r[3] ^ r[6] ^ r[8] ^ r[9] ^ r[10]};
  endfunction

  assign prn_ok   = (prn != '0) && (32'(prn) <= 32'd32);
  assign req_ok   = prn_valid && prn_ok;
  assign prn_sel  = 5'(prn - PRN_W'(1));
  assign req_taps = g2_taps(prn_sel);

  // One-hot tap selection keeps the G2 stage lookup free of variable indexing.
  genvar gi;
  generate
    for (gi = 1; gi <= 10; gi++) begin : g_tap_sel
      assign tap_hit_a[gi] = g2_reg[gi] & (taps_reg[7:4] == 4'(gi));
      assign tap_hit_b[gi] = g2_reg[gi] & (taps_reg[3:0] == 4'(gi));
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    g1_next         = g1_reg;
    g2_next         = g2_reg;
    idx_next        = idx_reg;
    ms_next         = ms_reg;
    taps_next       = taps_reg;
    pend_taps_next  = pend_taps_reg;
    pend_valid_next = pend_valid_reg;
    epoch_next      = 1'b0;
    bit_edge_next   = 1'b0;
    prn_err_next    = prn_valid && !prn_ok;
    steps           = 2'd1;
    wrap            = 1'b0;
`ifdef CA_CODE_SLEW_EN
    slew_armed_next = slew_armed_reg;
    slew_adv_next   = slew_adv_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (!stop && req_ok) begin
          state_next = RUN;
          taps_next  = req_taps;
        end
      end

      RUN: begin
        if (stop) begin
          state_next      = IDLE;
          g1_next         = '1;
          g2_next         = '1;
          idx_next        = '0;
          ms_next         = '0;
          pend_valid_next = 1'b0;
`ifdef CA_CODE_SLEW_EN
          slew_armed_next = 1'b0;
`endif
        end else begin
          // A new PRN waits for the epoch boundary so the code stays continuous.
          if (req_ok) begin
            pend_valid_next = 1'b1;
            pend_taps_next  = req_taps;
          end

`ifdef CA_CODE_SLEW_EN
          // A correction armed earlier is consumed here; a request in this
          // same cycle arms the following chip_en.
          if (chip_en && slew_armed_reg) begin
            steps           = slew_adv_reg ? 2'd2 : 2'd0;
            slew_armed_next = 1'b0;
          end
          if (slew_req) begin
            slew_armed_next = 1'b1;
            slew_adv_next   = slew_dir;
          end
`endif

          if (chip_en && (steps != 2'd0)) begin
            if (idx_reg == LAST_IDX) begin
              wrap     = 1'b1;
              g1_next  = '1;
              g2_next  = '1;
              idx_next = '0;
              if (steps == 2'd2) begin
                g1_next  = g1_step('1);
                g2_next  = g2_step('1);
                idx_next = 10'd1;
              end
            end else if ((steps == 2'd2) && (idx_reg != LAST_IDX - 10'd1)) begin
              g1_next  = g1_step(g1_step(g1_reg));
              g2_next  = g2_step(g2_step(g2_reg));
              idx_next = idx_reg + 10'd2;
            end else begin
              // Normal step; an advance at 1021 is clamped to 1022 so the
              // following chip_en performs the wrap.
              g1_next  = g1_step(g1_reg);
              g2_next  = g2_step(g2_reg);
              idx_next = idx_reg + 10'd1;
            end
          end

          if (wrap) begin
            epoch_next = 1'b1;
            if (ms_reg == MS_W'(MS_PER_BIT - 1)) begin
              ms_next       = '0;
              bit_edge_next = 1'b1;
            end else begin
              ms_next = ms_reg + MS_W'(1);
            end
            if (pend_valid_next) begin
              taps_next       = pend_taps_next;
              pend_valid_next = 1'b0;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      g1_reg         <= '1;
      g2_reg         <= '1;
      idx_reg        <= '0;
      ms_reg         <= '0;
      taps_reg       <= {4'd2, 4'd6};
      pend_taps_reg  <= {4'd2, 4'd6};
      pend_valid_reg <= 1'b0;
      epoch_reg      <= 1'b0;
      bit_edge_reg   <= 1'b0;
      prn_err_reg    <= 1'b0;
`ifdef CA_CODE_SLEW_EN
      slew_armed_reg <= 1'b0;
      slew_adv_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      g1_reg         <= g1_next;
      g2_reg         <= g2_next;
      idx_reg        <= idx_next;
      ms_reg         <= ms_next;
      taps_reg       <= taps_next;
      pend_taps_reg  <= pend_taps_next;
      pend_valid_reg <= pend_valid_next;
      epoch_reg      <= epoch_next;
      bit_edge_reg   <= bit_edge_next;
      prn_err_reg    <= prn_err_next;
`ifdef CA_CODE_SLEW_EN
      slew_armed_reg <= slew_armed_next;
      slew_adv_reg   <= slew_adv_next;
`endif
    end
  end

  assign running   = (state_reg == RUN);
  assign ca_chip   = running & (g1_reg[10] ^ (|tap_hit_a) ^ (|tap_hit_b));
  assign chip_idx  = idx_reg;
  assign epoch     = epoch_reg;
  assign bit_edge  = bit_edge_reg;
  assign prn_err   = prn_err_reg;
  assign prn_ready = ~rst;

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// -----------------------------------------------------------------------------
// tb_gps_ca_code_gen
//   Directed bench for gps_ca_code_gen. Stimulus pushes expected chips,
//   epochs and prn_err pulses into queues; a negedge monitor pops and
//   compares whenever the DUT presents the corresponding output.
//   Reference chip patterns: PRN1 = octal 1440, PRN2 = octal 1620.
// -----------------------------------------------------------------------------
module tb_gps_ca_code_gen;

  localparam int PRN_W      = 6;
  localparam int MS_PER_BIT = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             chip_en;
  logic             prn_valid;
  logic [PRN_W-1:0] prn;
  logic             stop;
  logic             prn_ready;
  logic             prn_err;
  logic             running;
  logic             ca_chip;
  logic [9:0]       chip_idx;
  logic             epoch;
  logic             bit_edge;
`ifdef CA_CODE_SLEW_EN
  logic             slew_req;
  logic             slew_dir;
`endif

  gps_ca_code_gen #(.PRN_W(PRN_W), .MS_PER_BIT(MS_PER_BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .chip_en   (chip_en),
    .prn_valid (prn_valid),
    .prn       (prn),
    .prn_ready (prn_ready),
    .prn_err   (prn_err),
    .stop      (stop),
    .running   (running),
    .ca_chip   (ca_chip),
    .chip_idx  (chip_idx),
    .epoch     (epoch),
    .bit_edge  (bit_edge)
`ifdef CA_CODE_SLEW_EN
    ,
    .slew_req  (slew_req),
    .slew_dir  (slew_dir)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  chip;
    int    idx;
  } chip_t;

  typedef struct {
    string name;
    logic  bedge;
    int    idx;
  } ep_t;

  chip_t chip_q[$];
  ep_t   ep_q[$];
  string err_q[$];

  int checks = 0;
  int errors = 0;
  int pos    = 0;   // expected chip index while running

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=1 required=0 (idx %0d)", name, chip_idx);
  endtask

  // ---------------- monitor ----------------
  chip_t mc;
  ep_t   me;
  string mn;

  always @(negedge clk) begin
    if (chip_en && running && (chip_q.size() > 0)) begin
      mc = chip_q.pop_front();
      chk({mc.name, "_chip"}, 32'(ca_chip), 32'(mc.chip));
      chk({mc.name, "_idx"}, 32'(chip_idx), mc.idx);
    end
    if (epoch) begin
      if (ep_q.size() == 0) begin
        unexpected("unexpected_epoch");
      end else begin
        me = ep_q.pop_front();
        chk({me.name, "_bit_edge"}, 32'(bit_edge), 32'(me.bedge));
        chk({me.name, "_idx"}, 32'(chip_idx), me.idx);
      end
    end else if (bit_edge) begin
      unexpected("bit_edge_without_epoch");
    end
    if (prn_err) begin
      if (err_q.size() == 0) begin
        unexpected("unexpected_prn_err");
      end else begin
        mn = err_q.pop_front();
        chk(mn, 32'(prn_err), 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chips(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      chip_en = 1'b1;
      tick();
      chip_en = 1'b0;
      pos = (pos + 1) % 1023;
      if (gap) tick();
    end
  endtask

  task automatic request(input logic [PRN_W-1:0] p);
    prn       = p;
    prn_valid = 1'b1;
    tick();
    prn_valid = 1'b0;
  endtask

  task automatic expect_chips(input string name, input logic [9:0] pattern);
    logic [9:0] pat;
    chip_t      c;
    pat = pattern;
    for (int i = 0; i < 10; i++) begin
      c.name = $sformatf("%s_%0d", name, i);
      c.chip = pat[9-i];
      c.idx  = pos + i;
      chip_q.push_back(c);
    end
  endtask

  task automatic expect_epoch(input string name, input logic be, input int idx);
    ep_t e;
    e.name  = name;
    e.bedge = be;
    e.idx   = idx;
    ep_q.push_back(e);
  endtask

  localparam logic [9:0] PRN1_PAT = 10'b1100100000;  // octal 1440
  localparam logic [9:0] PRN2_PAT = 10'b1110010000;  // octal 1620

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    chip_en   = 1'b0;
    prn_valid = 1'b0;
    prn       = '0;
    stop      = 1'b0;
`ifdef CA_CODE_SLEW_EN
    slew_req  = 1'b0;
    slew_dir  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    settle();
    chk("prn_ready_in_rst", 32'(prn_ready), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_ca_chip", 32'(ca_chip), 32'd0);
    chk("rst_chip_idx", 32'(chip_idx), 32'd0);
    chk("rst_epoch", 32'(epoch), 32'd0);
    chk("rst_bit_edge", 32'(bit_edge), 32'd0);
    chk("rst_prn_err", 32'(prn_err), 32'd0);
    chk("prn_ready_after_rst", 32'(prn_ready), 32'd1);
    tick();

    // chip_en in IDLE is ignored
    chips(3, 1'b1);
    pos = 0;
    settle();
    chk("idle_chip_idx", 32'(chip_idx), 32'd0);
    chk("idle_running", 32'(running), 32'd0);
    tick();

    // PRN1 start
    request(1);
    settle();
    chk("prn1_running", 32'(running), 32'd1);
    tick();
    expect_chips("prn1", PRN1_PAT);
    chips(10, 1'b1);
    settle();
    chk("prn1_idx_after_10", 32'(chip_idx), 32'd10);
    tick();

    // first wrap
    expect_epoch("epoch1", 1'b0, 0);
    chips(1023 - pos, 1'b0);
    settle();
    chk("wrap_chip_idx", 32'(chip_idx), 32'd0);
    chk("wrap_epoch_high", 32'(epoch), 32'd1);
    tick();
    settle();
    chk("epoch_single_cycle", 32'(epoch), 32'd0);
    tick();

    // PRN2 request right after the wrap stays pending: PRN1 continues
    request(2);
    expect_chips("prn1_continues", PRN1_PAT);
    chips(10, 1'b1);

    // second wrap applies PRN2
    expect_epoch("epoch2", 1'b0, 0);
    chips(1023 - pos, 1'b0);
    expect_chips("prn2_after_wrap", PRN2_PAT);
    chips(10, 1'b1);

    // mid-epoch requests: the later one overwrites the earlier
    chips(490, 1'b0);
    request(3);
    chips(5, 1'b0);
    request(1);
    expect_epoch("epoch3", 1'b0, 0);
    chips(1023 - pos, 1'b0);
    expect_chips("prn1_overwrite", PRN1_PAT);
    chips(10, 1'b1);

    // epochs 4..20; bit_edge only on the 20th
    for (int e = 4; e <= 20; e++) begin
      expect_epoch($sformatf("epoch%0d", e), (e == MS_PER_BIT) ? 1'b1 : 1'b0, 0);
      chips(1023 - pos, 1'b0);
    end
    chips(20, 1'b0);

    // invalid PRNs while running
    err_q.push_back("err_prn0_run");
    request(0);
    settle();
    chk("prn0_run_state", 32'(running), 32'd1);
    tick();
    err_q.push_back("err_prn33_run");
    request(33);
    settle();
    chk("prn33_run_state", 32'(running), 32'd1);
    tick();

    // stop with a simultaneous valid request: stop wins
    stop      = 1'b1;
    prn       = 6'd2;
    prn_valid = 1'b1;
    tick();
    stop      = 1'b0;
    prn_valid = 1'b0;
    settle();
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_chip_idx", 32'(chip_idx), 32'd0);
    chk("stop_ca_chip", 32'(ca_chip), 32'd0);
    tick();
    tick();
    settle();
    chk("stop_request_dropped", 32'(running), 32'd0);
    tick();
    pos = 0;

    // invalid PRNs in IDLE
    err_q.push_back("err_prn0_idle");
    request(0);
    err_q.push_back("err_prn33_idle");
    request(33);
    settle();
    chk("invalid_idle_state", 32'(running), 32'd0);
    tick();

    // fresh PRN2 start
    request(2);
    expect_chips("prn2_fresh", PRN2_PAT);
    chips(10, 1'b1);
    chips(490, 1'b0);
    settle();
    chk("pre_rst_idx", 32'(chip_idx), 32'd500);
    tick();

    // reset mid-epoch, with a chip strobe in the same cycle
    rst     = 1'b1;
    chip_en = 1'b1;
    tick();
    rst     = 1'b0;
    chip_en = 1'b0;
    settle();
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_chip_idx", 32'(chip_idx), 32'd0);
    chk("midrst_ca_chip", 32'(ca_chip), 32'd0);
    chk("midrst_epoch", 32'(epoch), 32'd0);
    chk("midrst_bit_edge", 32'(bit_edge), 32'd0);
    tick();
    pos = 0;

`ifdef CA_CODE_SLEW_EN
    request(1);
    chips(5, 1'b0);
    slew_dir = 1'b0;
    slew_req = 1'b1;
    tick();
    slew_req = 1'b0;
    chip_en  = 1'b1;
    tick();
    chip_en  = 1'b0;
    settle();
    chk("retard_idx_held", 32'(chip_idx), 32'd5);
    tick();
    chips(1022 - pos, 1'b0);
    slew_dir = 1'b1;
    slew_req = 1'b1;
    tick();
    slew_req = 1'b0;
    expect_epoch("advance_wrap", 1'b0, 1);
    chip_en = 1'b1;
    tick();
    chip_en = 1'b0;
    settle();
    chk("advance_idx", 32'(chip_idx), 32'd1);
    chk("advance_chip1", 32'(ca_chip), 32'd1);
    tick();
`endif

    repeat (3) tick();
    chk("chip_queue_drained", 32'(chip_q.size()), 32'd0);
    chk("epoch_queue_drained", 32'(ep_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
